program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Upstream boot stage for the single-cycle core: accepts a program image as a valid/ready word
//  stream, writes it to instruction memory, verifies a trailing 32-bit additive checksum, then
//  releases the core by driving its pcSelect/startAddress inputs. Core is held at startAddress
//  (pcSelect=1) whenever no verified image is present.
// PARAMETERS
//  ADDR_W       32  instruction-memory byte-address width (= core startAddress width)
//  DATA_W       32  instruction word width
//  CNT_W        16  word-count width
//  HOLD_CYCLES  2   cycles pcSelect stays high with final startAddress before release (>=1)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  start         in   1       1-cycle request to begin a load (sampled in IDLE/RUN/ERROR only)
//  baseAddress   in   ADDR_W  byte address of first word; latched on accepted start
//  wordCount     in   CNT_W   number of program words; latched on accepted start
//  inData        in   DATA_W  stream word (program words, then one checksum word)
//  inValid       in   1       inData valid
//  inReady       out  1       loader can accept inData this cycle
//  imemWrEn      out  1       instruction-memory write strobe
//  imemAddr      out  ADDR_W  instruction-memory byte write address
//  imemWrData    out  DATA_W  instruction-memory write data
//  pcSelect      out  1       to core: 1 = PC forced to startAddress, 0 = core runs
//  startAddress  out  ADDR_W  to core: program entry address
//  busy          out  1       high in LOAD, CHECK, RELEASE
//  done          out  1       high in RUN
//  error         out  1       high in ERROR
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; pcSelect=1; inReady, imemWrEn, busy, done, error = 0;
//   imemAddr, imemWrData, startAddress, internal index/sum = 0. Memory contents not cleared.
//  States: IDLE, LOAD, CHECK, RELEASE, RUN, ERROR. All outputs registered.
//  IDLE/RUN/ERROR + start=1: latch base, count; index=0, sum=0; pcSelect=1 next cycle.
//   -> ERROR if wordCount==0 or baseAddress[1:0]!=0; else -> LOAD.
//  start while busy is ignored (no restart, no error).
//  LOAD: inReady=1. Transfer = inValid&inReady. Per transfer: next cycle imemWrEn=1,
//   imemAddr=base+4*index (mod 2^ADDR_W, wraps silently), imemWrData=inData; sum+=inData
//   (mod 2^32); index++. imemWrEn is a single-cycle pulse per transfer; back-to-back transfers
//   give consecutive write pulses. After transfer with index==count-1 -> CHECK.
//  CHECK: inReady=1; next transfer is the checksum word, never written to memory.
//   inData==sum -> RELEASE; mismatch -> ERROR. inReady drops the cycle after this transfer.
//  RELEASE: startAddress=base, pcSelect=1 for exactly HOLD_CYCLES cycles, then -> RUN.
//  RUN: pcSelect=0, done=1; startAddress holds base. Core executes until new start.
//  ERROR: pcSelect=1, error=1, inReady=0; left only by start or reset.
//  inValid while inReady=0 is ignored (word not consumed). Stalls (inValid=0) of any length
//   are legal in LOAD/CHECK; no timeout.
//  Reset mid-load: immediate IDLE, pcSelect=1; partially written words remain in memory.
//  Latency: accepted word -> write strobe 1 cycle; checksum transfer -> pcSelect=0 after
//   1 + HOLD_CYCLES cycles.
// TESTING
//  1 Reset: rst_n low mid-cycle -> pcSelect=1, inReady=0, imemWrEn=0, done=0, error=0 at once.
//  2 base=0x100, count=3, words 0x11,0x22,0x33, checksum 0x66 -> writes at 0x100/0x104/0x108,
//    pcSelect low 3 cycles after checksum transfer, startAddress=0x100, done=1.
//  3 Same image, checksum 0x67 -> error=1, pcSelect stays 1, no 4th memory write.
//  4 base=0xFFFFFFF8, count=3, random inValid gaps -> addresses 0xFFFFFFF8, 0xFFFFFFFC,
//    0x00000000; writes only on handshake; sum wraps mod 2^32.
//  5 count=0 or base=0x102 -> ERROR; then valid start -> normal load completes.
//  6 start pulsed during LOAD ignored; rst_n pulsed after 2 of 4 words -> IDLE, reload succeeds.

Source files
------------

// File: rtl/program_loader_if.sv
// Program-image stream and instruction-memory write port between the boot source,
// the loader and instruction memory.
interface program_loader_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] inData;
   logic              inValid;
   logic              inReady;
   logic              imemWrEn;
   logic [ADDR_W-1:0] imemAddr;
   logic [DATA_W-1:0] imemWrData;

   modport master (
      output inData, inValid,
      input  inReady, imemWrEn, imemAddr, imemWrData
   );

   modport slave (
      input  inData, inValid,
      output inReady, imemWrEn, imemAddr, imemWrData
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: streams a program image into instruction memory, verifies its trailing
// additive checksum and releases the core at the image base address.
module program_loader #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_baseAddress,
   input  logic [CNT_W-1:0]  i_wordCount,
   program_loader_if.slave   bus,
   output logic              o_pcSelect,
   output logic [ADDR_W-1:0] o_startAddress,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_RUN, S_ERROR
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [CNT_W-1:0]  r_index, w_index_nxt;
   logic [DATA_W-1:0] r_sum, w_sum_nxt;
   logic [HOLD_W-1:0] r_hold, w_hold_nxt;
   logic              r_in_ready;
   logic              r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
   logic [ADDR_W-1:0] r_start_addr, w_start_addr_nxt;
   logic              r_pc_sel, r_busy, r_done, r_error;
   logic              w_xfer;

   // inReady is registered and tracks the state, so it qualifies the handshake directly
   assign w_xfer = bus.inValid & r_in_ready;

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt      = r_state;
      w_base_nxt       = r_base;
      w_count_nxt      = r_count;
      w_index_nxt      = r_index;
      w_sum_nxt        = r_sum;
      w_hold_nxt       = r_hold;
      w_wr_en_nxt      = 1'b0;
      w_addr_nxt       = r_addr;
      w_wr_data_nxt    = r_wr_data;
      w_start_addr_nxt = r_start_addr;
      case (r_state)
         S_IDLE, S_RUN, S_ERROR: begin
            if (i_start) begin
               w_base_nxt  = i_baseAddress;
               w_count_nxt = i_wordCount;
               w_index_nxt = '0;
               w_sum_nxt   = '0;
               if ((i_wordCount == '0) || (i_baseAddress[1:0] != 2'b00)) w_state_nxt = S_ERROR;
               else                                                       w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_wr_en_nxt   = 1'b1;
               w_addr_nxt    = r_base + (ADDR_W'(r_index) << 2);
               w_wr_data_nxt = bus.inData;
               w_sum_nxt     = r_sum + bus.inData;
               w_index_nxt   = r_index + CNT_W'(1);
               if (r_index == (r_count - CNT_W'(1))) w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_xfer) begin
               if (bus.inData == r_sum) begin
                  w_state_nxt      = S_RELEASE;
                  w_hold_nxt       = '0;
                  w_start_addr_nxt = r_base;
               end else begin
                  w_state_nxt = S_ERROR;
               end
            end
         end
         S_RELEASE: begin
            if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) w_state_nxt = S_RUN;
            else                                     w_hold_nxt  = r_hold + HOLD_W'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs; status flags are decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_base       <= '0;
         r_count      <= '0;
         r_index      <= '0;
         r_sum        <= '0;
         r_hold       <= '0;
         r_in_ready   <= 1'b0;
         r_wr_en      <= 1'b0;
         r_addr       <= '0;
         r_wr_data    <= '0;
         r_start_addr <= '0;
         r_pc_sel     <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_base       <= w_base_nxt;
         r_count      <= w_count_nxt;
         r_index      <= w_index_nxt;
         r_sum        <= w_sum_nxt;
         r_hold       <= w_hold_nxt;
         r_in_ready   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CHECK);
         r_wr_en      <= w_wr_en_nxt;
         r_addr       <= w_addr_nxt;
         r_wr_data    <= w_wr_data_nxt;
         r_start_addr <= w_start_addr_nxt;
         r_pc_sel     <= (w_state_nxt != S_RUN);
         r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CHECK) ||
                         (w_state_nxt == S_RELEASE);
         r_done       <= (w_state_nxt == S_RUN);
         r_error      <= (w_state_nxt == S_ERROR);
      end
   end

   assign bus.inReady    = r_in_ready;
   assign bus.imemWrEn   = r_wr_en;
   assign bus.imemAddr   = r_addr;
   assign bus.imemWrData = r_wr_data;
   assign o_pcSelect     = r_pc_sel;
   assign o_startAddress = r_start_addr;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a transaction-level reference model predicts every
// output each cycle; directed scenarios pin the model with literal expectations.
module tb_program_loader;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned HOLD   = 2;

   localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_REL = 3, P_RUN = 4, P_ERR = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_address = '0;
   logic [CNT_W-1:0]  word_count = '0;
   logic              pc_select, busy, done, error;
   logic [ADDR_W-1:0] start_address;

   int n_checks = 0;
   int n_fail   = 0;

   program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (start),
      .i_baseAddress  (base_address),
      .i_wordCount    (word_count),
      .bus            (bus),
      .o_pcSelect     (pc_select),
      .o_startAddress (start_address),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase plus the words still owed, advanced once per clock edge
   int          m_phase = P_IDLE;
   logic [31:0] m_base = '0, m_sum = '0, m_saddr = '0, m_waddr = '0, m_wdata = '0;
   int          m_count = 0, m_idx = 0, m_hold = 0;
   logic        m_ready = 1'b0, m_wr = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_IDLE; m_base = '0; m_sum = '0; m_saddr = '0;
         m_count = 0; m_idx = 0; m_hold = 0; m_ready = 1'b0; m_wr = 1'b0;
      end else begin
         logic xfer;
         xfer = bus.inValid && m_ready;
         m_wr = 1'b0;
         if ((m_phase == P_IDLE || m_phase == P_RUN || m_phase == P_ERR) && start) begin
            m_base  = base_address;
            m_count = int'(word_count);
            m_idx   = 0;
            m_sum   = '0;
            m_phase = (m_count == 0 || base_address % 4 != 0) ? P_ERR : P_LOAD;
         end else if (m_phase == P_LOAD && xfer) begin
            m_wr    = 1'b1;
            m_waddr = m_base + 32'(m_idx) * 32'd4;
            m_wdata = bus.inData;
            m_sum   = m_sum + bus.inData;
            m_idx++;
            if (m_idx == m_count) m_phase = P_CHECK;
         end else if (m_phase == P_CHECK && xfer) begin
            if (bus.inData == m_sum) begin
               m_phase = P_REL;
               m_hold  = HOLD;
               m_saddr = m_base;
            end else begin
               m_phase = P_ERR;
            end
         end else if (m_phase == P_REL) begin
            m_hold--;
            if (m_hold == 0) m_phase = P_RUN;
         end
         m_ready = (m_phase == P_LOAD || m_phase == P_CHECK);
      end
   end

   logic [31:0] wlog[$];
   logic [31:0] dlog[$];

   // Compare every output against the model, away from the active edge
   always @(negedge clk) begin
      check("inReady", 64'(bus.inReady), 64'(m_ready));
      check("imemWrEn", 64'(bus.imemWrEn), 64'(m_wr));
      if (m_wr) begin
         check("imemAddr", 64'(bus.imemAddr), 64'(m_waddr));
         check("imemWrData", 64'(bus.imemWrData), 64'(m_wdata));
      end
      check("pcSelect", 64'(pc_select), 64'(m_phase != P_RUN));
      check("startAddress", 64'(start_address), 64'(m_saddr));
      check("busy", 64'(busy), 64'(m_phase == P_LOAD || m_phase == P_CHECK || m_phase == P_REL));
      check("done", 64'(done), 64'(m_phase == P_RUN));
      check("error", 64'(error), 64'(m_phase == P_ERR));
      if (bus.imemWrEn === 1'b1) begin
         wlog.push_back(bus.imemAddr);
         dlog.push_back(bus.imemWrData);
      end
   end

   logic [31:0] img[$];

   function automatic logic [31:0] img_sum();
      logic [31:0] s = '0;
      foreach (img[i]) s = s + img[i];
      return s;
   endfunction

   // Called at a negedge; returns at a negedge
   task automatic pulse_start(input logic [31:0] b, input int c);
      start = 1'b1; base_address = b; word_count = CNT_W'(c);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int gap_max);
      bit took = 1'b0;
      int gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (gap) @(negedge clk);
      bus.inValid = 1'b1;
      bus.inData  = d;
      for (int t = 0; t < 100 && !took; t++) begin
         took = bus.inReady;
         @(negedge clk);
      end
      bus.inValid = 1'b0;
      bus.inData  = $urandom;
      if (!took) begin
         n_checks++; n_fail++;
         $display("FAIL handshake_timeout: word %h not accepted within 100 cycles", d);
      end
   endtask

   task automatic drive_junk(input int k);
      for (int i = 0; i < k; i++) begin
         bus.inValid = $urandom_range(1, 0) == 1;
         bus.inData  = $urandom;
         @(negedge clk);
      end
      bus.inValid = 1'b0;
   endtask

   task automatic load(input logic [31:0] b, input logic [31:0] csum, input int gap);
      wlog.delete(); dlog.delete();
      pulse_start(b, img.size());
      foreach (img[i]) send_word(img[i], gap);
      send_word(csum, gap);
      repeat (HOLD + 3) @(negedge clk);
   endtask

   initial begin
      int n;
      bus.inValid = 1'b0;
      bus.inData  = '0;
      // 1: reset values
      repeat (2) @(negedge clk);
      check("rst_pcSelect", 64'(pc_select), 64'd1);
      check("rst_inReady", 64'(bus.inReady), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      rst_n = 1'b1;
      drive_junk(4);

      // 2: basic image, latency to release
      img = '{32'h11, 32'h22, 32'h33};
      wlog.delete(); dlog.delete();
      pulse_start(32'h100, 3);
      foreach (img[i]) send_word(img[i], 0);
      send_word(32'h66, 0);
      n = 1;
      while (pc_select && n < 20) begin @(negedge clk); n++; end
      check("t2_release_latency", 64'(n), 64'd3);
      check("t2_nwrites", 64'(wlog.size()), 64'd3);
      if (wlog.size() == 3) begin
         check("t2_addr0", 64'(wlog[0]), 64'h100);
         check("t2_addr1", 64'(wlog[1]), 64'h104);
         check("t2_addr2", 64'(wlog[2]), 64'h108);
         check("t2_data2", 64'(dlog[2]), 64'h33);
      end
      check("t2_startAddress", 64'(start_address), 64'h100);
      check("t2_done", 64'(done), 64'd1);

      // 3: bad checksum
      load(32'h100, 32'h67, 0);
      check("t3_error", 64'(error), 64'd1);
      check("t3_pcSelect", 64'(pc_select), 64'd1);
      check("t3_nwrites", 64'(wlog.size()), 64'd3);

      // 4: address wrap, gaps, checksum wrap
      img = '{32'hF000_0000, 32'h2000_0000, 32'h0000_0005};
      load(32'hFFFF_FFF8, 32'h1000_0005, 3);
      check("t4_nwrites", 64'(wlog.size()), 64'd3);
      if (wlog.size() == 3) begin
         check("t4_addr0", 64'(wlog[0]), 64'hFFFF_FFF8);
         check("t4_addr1", 64'(wlog[1]), 64'hFFFF_FFFC);
         check("t4_addr2", 64'(wlog[2]), 64'h0000_0000);
      end
      check("t4_done", 64'(done), 64'd1);

      // 5: rejected starts, then a good load
      pulse_start(32'h200, 0);
      drive_junk(3);
      check("t5_count0_error", 64'(error), 64'd1);
      pulse_start(32'h102, 2);
      drive_junk(3);
      check("t5_misaligned_error", 64'(error), 64'd1);
      img = '{32'hDEAD_BEEF};
      load(32'h300, 32'hDEAD_BEEF, 1);
      check("t5_recover_done", 64'(done), 64'd1);

      // 6: start ignored while loading, reset mid-load, reload
      img = '{32'h1, 32'h2, 32'h3, 32'h4};
      wlog.delete(); dlog.delete();
      pulse_start(32'h400, 4);
      send_word(img[0], 0);
      pulse_start(32'h8000, 1);
      send_word(img[1], 0);
      check("t6_busy_after_restart", 64'(busy), 64'd1);
      @(posedge clk); #2 rst_n = 1'b0; #1;
      check("t6_rst_pcSelect", 64'(pc_select), 64'd1);
      check("t6_rst_inReady", 64'(bus.inReady), 64'd0);
      check("t6_rst_imemWrEn", 64'(bus.imemWrEn), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      check("t6_rst_error", 64'(error), 64'd0);
      check("t6_partial_writes", 64'(wlog.size()), 64'd2);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      load(32'h400, 32'hA, 2);
      check("t6_reload_done", 64'(done), 64'd1);
      if (wlog.size() == 4) check("t6_addr3", 64'(wlog[3]), 64'h40C);

      // Random images, some with corrupt checksums or rejected starts
      for (int it = 0; it < 30; it++) begin
         int          cnt = $urandom_range(6, 1);
         logic [31:0] b = $urandom & 32'hFFFF_FFFC;
         img.delete();
         for (int i = 0; i < cnt; i++) img.push_back($urandom);
         if ($urandom_range(5, 0) == 0) begin
            pulse_start(b | 32'h1, cnt);
            drive_junk(4);
         end else begin
            load(b, ($urandom_range(2, 0) == 0) ? img_sum() + 32'h1 : img_sum(),
                 $urandom_range(3, 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
